// File: rtl/nlfm_pulse_capture_if.sv
// Valid/ready sample stream from the pulse capture buffer to the pulse-compression correlator.
interface nlfm_pulse_capture_if #(
    parameter int ADDR_W = 9
);
    logic [15:0]       m_data;
    logic [ADDR_W-1:0] m_index;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_index, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_index, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/nlfm_pulse_capture.sv
// Captures one NLFM pulse after the mid-scale dead time and drains it as a valid/ready frame.
// Optional macro PEAK_DETECT_EN adds peak magnitude/index outputs for each captured pulse.
module nlfm_pulse_capture #(
    parameter int PULSE_LEN = 320,
    parameter int ADDR_W    = 9,
    parameter int IDLE_MIN  = 64
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [15:0]          signal,
    nlfm_pulse_capture_if.master m_if,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    output logic                 overrun
`ifdef PEAK_DETECT_EN
    ,
    output logic [15:0]          peak_mag,
    output logic [ADDR_W-1:0]    peak_idx,
    output logic                 peak_valid
`endif
);
    localparam int IW = $clog2(IDLE_MIN + 1);
    localparam int CW = ADDR_W + 1;
    localparam logic [IW-1:0]     IDLE_MAX = IW'(IDLE_MIN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PULSE_LEN - 1);
    localparam logic [CW-1:0]     RD_END   = CW'(PULSE_LEN);

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    function automatic logic [15:0] to_signed(input logic [15:0] s);
        to_signed = {~s[15], s[14:0]};
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       s_q;
    logic [IW-1:0]     idle_q, idle_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              r_vld_q, r_vld_d;
    logic [ADDR_W-1:0] r_idx_q, r_idx_d;
    logic [15:0]       r_data_q;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [15:0]       m_data_q, m_data_d;
    logic [ADDR_W-1:0] m_index_q, m_index_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              overrun_q, overrun_d, busy_q;
    logic              wr_en_s, rd_issue_s, mid_s, start_evt_s;
    logic              s1_free_s, s2_free_s, last_beat_s;
    logic [15:0]       mem [PULSE_LEN];

    assign mid_s       = (s_q == 16'h8000);
    assign start_evt_s = (idle_q == IDLE_MAX) && !mid_s;
    // Two-stage read pipeline (RAM register, output register); each stage advances when the next frees up.
    assign s2_free_s   = !m_valid_q || m_if.m_ready;
    assign s1_free_s   = !r_vld_q || s2_free_s;
    assign last_beat_s = m_valid_q && m_if.m_ready && m_last_q;

    // Next-state, idle counting, buffer write control and read issue.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_cnt_d    = rd_cnt_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        wr_en_s     = 1'b0;
        rd_issue_s  = 1'b0;
        if (mid_s) begin
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
        end else begin
            idle_d = IW'(0);
        end
        case (state_q)
            ST_ARM: begin
                if ((idle_q == IDLE_MAX) && enable) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_ARM;
                    idle_d  = IW'(0);
                end else if (start_evt_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_d = ADDR_W'(1);
                    state_d  = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                wr_en_s = 1'b1;
                if (wr_idx_q == LAST_IDX) begin
                    wr_idx_d = ADDR_W'(0);
                    state_d  = ST_DRAIN;
                end else begin
                    wr_idx_d = wr_idx_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (start_evt_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                rd_issue_s = s1_free_s && (rd_cnt_q != RD_END);
                if (rd_issue_s) begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
                if (last_beat_s) begin
                    state_d     = ST_ARM;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    rd_cnt_d    = CW'(0);
                    idle_d      = IW'(0);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // Read pipeline stage and output register advance.
    always_comb begin
        r_vld_d   = r_vld_q;
        r_idx_d   = r_idx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
        if (s1_free_s) begin
            r_vld_d = rd_issue_s;
            r_idx_d = rd_cnt_q[ADDR_W-1:0];
        end else begin
            r_vld_d = r_vld_q;
        end
        if (s2_free_s) begin
            m_valid_d = r_vld_q;
            if (r_vld_q) begin
                m_data_d  = r_data_q;
                m_index_d = r_idx_q;
                m_last_d  = (r_idx_q == LAST_IDX);
            end else begin
                m_last_d  = 1'b0;
            end
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Capture buffer: write port plus registered read port (contents need no reset).
    always_ff @(posedge CLOCK_50) begin
        if (wr_en_s) begin
            mem[wr_idx_q] <= to_signed(s_q);
        end
        if (rd_issue_s) begin
            r_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
        end
    end

    // Control and output registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ARM;
            s_q         <= 16'h0000;
            idle_q      <= IW'(0);
            wr_idx_q    <= ADDR_W'(0);
            rd_cnt_q    <= CW'(0);
            r_vld_q     <= 1'b0;
            r_idx_q     <= ADDR_W'(0);
            m_valid_q   <= 1'b0;
            m_data_q    <= 16'h0000;
            m_index_q   <= ADDR_W'(0);
            m_last_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= signal;
            idle_q      <= idle_d;
            wr_idx_q    <= wr_idx_d;
            rd_cnt_q    <= rd_cnt_d;
            r_vld_q     <= r_vld_d;
            r_idx_q     <= r_idx_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_index_q   <= m_index_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            busy_q      <= (state_d == ST_CAPTURE) || (state_d == ST_DRAIN);
        end
    end

    assign m_if.m_data  = m_data_q;
    assign m_if.m_index = m_index_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_last  = m_last_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_cnt_q;
    assign overrun      = overrun_q;

`ifdef PEAK_DETECT_EN
    function automatic logic [15:0] mag_sat(input logic [15:0] v);
        if (v == 16'h8000) begin
            mag_sat = 16'h7FFF;
        end else if (v[15]) begin
            mag_sat = 16'h0000 - v;
        end else begin
            mag_sat = v;
        end
    endfunction

    logic [15:0]       abs_s, run_mag_q, run_mag_d, peak_mag_q, peak_mag_d;
    logic [ADDR_W-1:0] run_idx_q, run_idx_d, peak_idx_q, peak_idx_d;
    logic              peak_valid_q, peak_valid_d;

    // Running maximum restarts at index 0; strict compare keeps the first index of a tie.
    always_comb begin
        abs_s        = mag_sat(to_signed(s_q));
        run_mag_d    = run_mag_q;
        run_idx_d    = run_idx_q;
        peak_mag_d   = peak_mag_q;
        peak_idx_d   = peak_idx_q;
        peak_valid_d = 1'b0;
        if (wr_en_s) begin
            if ((wr_idx_q == ADDR_W'(0)) || (abs_s > run_mag_q)) begin
                run_mag_d = abs_s;
                run_idx_d = wr_idx_q;
            end else begin
                run_mag_d = run_mag_q;
            end
            if (wr_idx_q == LAST_IDX) begin
                peak_mag_d   = run_mag_d;
                peak_idx_d   = run_idx_d;
                peak_valid_d = 1'b1;
            end else begin
                peak_valid_d = 1'b0;
            end
        end else begin
            peak_valid_d = 1'b0;
        end
    end

    // Peak tracking registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            run_mag_q    <= 16'h0000;
            run_idx_q    <= ADDR_W'(0);
            peak_mag_q   <= 16'h0000;
            peak_idx_q   <= ADDR_W'(0);
            peak_valid_q <= 1'b0;
        end else begin
            run_mag_q    <= run_mag_d;
            run_idx_q    <= run_idx_d;
            peak_mag_q   <= peak_mag_d;
            peak_idx_q   <= peak_idx_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_mag   = peak_mag_q;
    assign peak_idx   = peak_idx_q;
    assign peak_valid = peak_valid_q;
`endif
endmodule
